// File: rtl/can_pkg.sv
// Shared definitions for the CAN microcontroller bus controller.
//   - FSM state encoding
//   - address/data widths and the address-map constants
//   - wait-counter width (RD_WAIT range 0..7)
//   - held-request struct
//   - write-valid / read-valid address decode functions
package can_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;
  localparam int RD_WAIT_W = 3;

  // Register map boundaries
  localparam logic [ADDR_W-1:0] WR_LO0_MAX = 6'h03;
  localparam logic [ADDR_W-1:0] WR_SINGLE  = 6'h05;
  localparam logic [ADDR_W-1:0] WR_MID_MIN = 6'h08;
  localparam logic [ADDR_W-1:0] WR_MID_MAX = 6'h11;
  localparam logic [ADDR_W-1:0] WR_HI_MIN  = 6'h18;
  localparam logic [ADDR_W-1:0] WR_HI_MAX  = 6'h20;
  localparam logic [ADDR_W-1:0] RD_MAX     = 6'h20;

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, WAIT_RD, DONE
  } state_t;

  // Request captured in IDLE and held for the whole transfer
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mc_req_t;

  function automatic logic wr_addr_valid(input logic [ADDR_W-1:0] a);
    return (a <= WR_LO0_MAX) || (a == WR_SINGLE) ||
           (a >= WR_MID_MIN && a <= WR_MID_MAX) ||
           (a >= WR_HI_MIN  && a <= WR_HI_MAX);
  endfunction

  function automatic logic rd_addr_valid(input logic [ADDR_W-1:0] a);
    return a <= RD_MAX;
  endfunction

endpackage

// File: rtl/can_addr_check.sv
// Combinational address validator.
//   addr  : held register address
//   wr    : direction, 1 = write, 0 = read
//   valid : address exists in the map for that direction
module can_addr_check
  import can_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  output logic              valid
);

  assign valid = wr ? wr_addr_valid(addr) : rd_addr_valid(addr);

endmodule

// File: rtl/can_mc_bus_ctrl.sv
// Microcontroller-to-register-bus transfer controller.
// One request handshake per i_req rising level: capture request, validate
// address, strobe the write or read channel once, optionally wait RD_WAIT
// cycles for read data, then hold ack until the request is withdrawn.
// Ports:
//   i_clk, i_reset          clock, async active-high reset
//   i_req/i_wr/i_mc_addr/i_mc_wdata  microcontroller request
//   o_ack/o_err/o_mc_rdata  completion, invalid-address flag, read data
//   o_busy                  not IDLE
//   o_wr_en/o_rd_en         one-cycle channel strobes
//   o_addr/o_bus_data       held address / write data to the channels
//   i_reg_r_bus             read data from the read channel
module can_mc_bus_ctrl
  import can_pkg::*;
#(
  parameter int RD_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_mc_addr,
  input  logic [DATA_W-1:0] i_mc_wdata,
  output logic              o_ack,
  output logic              o_err,
  output logic [DATA_W-1:0] o_mc_rdata,
  output logic              o_busy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_reg_r_bus
);

  // Counter is loaded with RD_WAIT-1 so WAIT_RD lasts RD_WAIT cycles.
  localparam logic [RD_WAIT_W-1:0] WAIT_LD =
    (RD_WAIT > 0) ? RD_WAIT_W'(RD_WAIT - 1) : '0;

  state_t               state_q, state_d;
  mc_req_t              req_q;
  logic                 err_q;
  logic [RD_WAIT_W-1:0] wait_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 addr_ok;

  can_addr_check u_addr_check (
    .addr  (req_q.addr),
    .wr    (req_q.wr),
    .valid (addr_ok)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Strobes and ack decode straight from state so reset kills them at once.
  always_comb begin
    state_d    = state_q;
    o_busy     = (state_q != IDLE);
    o_wr_en    = 1'b0;
    o_rd_en    = 1'b0;
    o_ack      = 1'b0;
    o_err      = 1'b0;
    o_addr     = req_q.addr;
    o_bus_data = req_q.wdata;
    o_mc_rdata = rdata_q;
    case (state_q)
      IDLE:    if (i_req) state_d = SETUP;
      SETUP:   state_d = addr_ok ? ACCESS : DONE;
      ACCESS: begin
        o_wr_en = req_q.wr;
        o_rd_en = !req_q.wr;
        if (req_q.wr || RD_WAIT == 0) state_d = DONE;
        else                          state_d = WAIT_RD;
      end
      WAIT_RD: if (wait_q == '0) state_d = DONE;
      DONE: begin
        o_ack = 1'b1;
        o_err = err_q;
        // Waiting for i_req low here is what makes a held request one transfer.
        if (!i_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      req_q   <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_req) begin
          req_q <= '{wr: i_wr, addr: i_mc_addr, wdata: i_mc_wdata};
          err_q <= 1'b0;
        end
        SETUP: err_q <= !addr_ok;
        ACCESS: if (!req_q.wr) begin
          wait_q <= WAIT_LD;
          if (RD_WAIT == 0) rdata_q <= i_reg_r_bus;
        end
        WAIT_RD: begin
          if (wait_q == '0) rdata_q <= i_reg_r_bus;
          else              wait_q  <= wait_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/can_mc_bus_ctrl.md
CAN_MC_BUS_CTRL -- requirements
Module: can_mc_bus_ctrl

Interface
REQ-001 SHALL have parameter RD_WAIT, default 1, meaning the number of wait cycles between the read strobe and read-data capture (legal range 0..7).
REQ-002 SHALL have port i_clk, input, 1, the single system clock; all state changes on the rising edge.
REQ-003 SHALL have port i_reset, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port i_req, input, 1, microcontroller transfer request, synchronous to i_clk.
REQ-005 SHALL have port i_wr, input, 1, transfer direction: 1 = write, 0 = read.
REQ-006 SHALL have port i_mc_addr, input, 6, microcontroller register address.
REQ-007 SHALL have port i_mc_wdata, input, 32, microcontroller write data.
REQ-008 SHALL have port o_ack, output, 1, transfer-complete acknowledge.
REQ-009 SHALL have port o_err, output, 1, invalid-address flag, qualified by o_ack.
REQ-010 SHALL have port o_mc_rdata, output, 32, read data returned to the microcontroller.
REQ-011 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port o_wr_en, output, 1, write-channel enable strobe.
REQ-013 SHALL have port o_addr, output, 6, register address to the write and read channels.
REQ-014 SHALL have port o_bus_data, output, 32, write data to the write channel.
REQ-015 SHALL have port o_rd_en, output, 1, read-channel enable strobe.
REQ-016 SHALL have port i_reg_r_bus, input, 32, read data from the read channel.

Function
REQ-017 SHALL implement the states IDLE, SETUP, ACCESS, WAIT_RD and DONE.
REQ-018 In IDLE, when i_req=1, SHALL capture i_wr, i_mc_addr and i_mc_wdata into holding registers and go to SETUP; later changes on these inputs SHALL be ignored until the next IDLE.
REQ-019 In SETUP, SHALL check the held address and go to ACCESS if valid, or to DONE with o_err=1 if invalid.
- Write-valid set: 0x00-0x03, 0x05, 0x08-0x11, 0x18-0x20.
- Read-valid set: 0x00-0x20.
REQ-020 In ACCESS for a write, SHALL assert o_wr_en for exactly one cycle with o_addr and o_bus_data driven from the holding registers, then go to DONE.
REQ-021 In ACCESS for a read, SHALL assert o_rd_en for exactly one cycle, then go to WAIT_RD if RD_WAIT>0, else to DONE.
REQ-022 When RD_WAIT=0, SHALL capture i_reg_r_bus into o_mc_rdata on the ACCESS->DONE edge.
REQ-023 WAIT_RD SHALL last exactly RD_WAIT cycles, counted by a 3-bit down-counter; SHALL capture i_reg_r_bus into o_mc_rdata on the WAIT_RD->DONE edge.
REQ-024 In DONE, SHALL hold o_ack=1 (and o_err as decided in SETUP) until i_req=0 is sampled, then go to IDLE; o_ack and o_err SHALL be 0 in IDLE.
REQ-025 Write latency: req sampled at edge N; o_wr_en high during cycle N+1..N+2; o_ack high from edge N+2.
REQ-026 Read latency: o_ack rises 2+RD_WAIT cycles after req is sampled.
REQ-027 o_wr_en and o_rd_en SHALL never be high in the same cycle, and SHALL never be high for an invalid address.
REQ-028 o_mc_rdata SHALL hold its last captured value across writes and errored transfers.
REQ-029 o_addr and o_bus_data SHALL hold the last captured values outside ACCESS.
REQ-030 i_req held high continuously SHALL produce exactly one transfer; a new transfer requires i_req low then high again.

Reset
REQ-031 On i_reset=1, SHALL immediately force state IDLE and drive o_ack, o_err, o_busy, o_wr_en and o_rd_en to 0, and o_mc_rdata, o_addr, o_bus_data and the wait counter to 0.
REQ-032 A reset mid-transfer SHALL abort it with no strobe emitted after reset asserts; after release, a still-high i_req SHALL start a fresh transfer.

Structure
REQ-033 Package can_pkg SHALL hold:
- the state enum;
- the address constants;
- the RD_WAIT width;
- the write-valid and read-valid address functions.
REQ-034 SHALL instantiate one sub-module, can_addr_check (combinational, held address + direction -> valid), reusable by the write and read channels.

Verification
REQ-035 Write 0x05, data 0xDEADBEEF -> o_wr_en one cycle, 2 cycles after req, with o_addr=0x05 and o_bus_data=0xDEADBEEF; o_ack=1, o_err=0 next cycle.
REQ-036 Read 0x04 with RD_WAIT=1 and i_reg_r_bus=0x12345678 -> o_rd_en one cycle; o_mc_rdata=0x12345678 and o_ack at cycle 3.
REQ-037 Write 0x04 (invalid) -> no o_wr_en; o_ack=1 and o_err=1 two cycles after req.
REQ-038 Hold i_req high 10 cycles on a write, changing i_mc_wdata mid-way -> single o_wr_en carrying the first data; o_ack drops one cycle after i_req drops.
REQ-039 Assert i_reset during WAIT_RD -> all outputs 0 at once; after release, with i_req=0, state stays IDLE with no ack.
REQ-040 Back-to-back write 0x20 then read 0x21 with RD_WAIT=0 -> one o_wr_en, then o_err=1 with no o_rd_en.
